// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet controller: FSM state codes,
// protocol bytes exchanged with the mouse, and bit positions inside packet byte0.
// Pure declarations; no timing or flow-control behaviour of its own.
package mouse_pkg;

    localparam logic [2:0] ST_WAIT_BAT = 3'd0;
    localparam logic [2:0] ST_WAIT_ID  = 3'd1;
    localparam logic [2:0] ST_SEND     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_PKT0     = 3'd4;
    localparam logic [2:0] ST_PKT1     = 3'd5;
    localparam logic [2:0] ST_PKT2     = 3'd6;
    localparam logic [2:0] ST_FAIL     = 3'd7;

    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;

    localparam int B0_LEFT  = 0;
    localparam int B0_RIGHT = 1;
    localparam int B0_SYNC  = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    // Stream mode covers the three packet-byte states.
    function automatic logic is_stream(input logic [2:0] st);
        return (st == ST_PKT0) || (st == ST_PKT1) || (st == ST_PKT2);
    endfunction

endpackage

// File: rtl/mouse_timeout_ctr.sv
// Saturating idle-cycle counter with terminal flags for the byte gap and ACK timeouts.
// Flags are registered-count compares: valid the cycle after the count reaches the limit.
// No backpressure; clr has priority over counting.
module mouse_timeout_ctr
    import mouse_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 100000,
    parameter int ACK_TIMEOUT  = 1250000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic byte_to,
    output logic ack_to
);

    localparam int CNT_MAX = (BYTE_TIMEOUT > ACK_TIMEOUT) ? BYTE_TIMEOUT : ACK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
    localparam logic [CW-1:0] BYTE_TC = CW'(BYTE_TIMEOUT);
    localparam logic [CW-1:0] ACK_TC  = CW'(ACK_TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at the larger limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign byte_to = (cnt_q >= BYTE_TC);
    assign ack_to  = (cnt_q >= ACK_TC);

endmodule

// File: rtl/ps2_mouse_packet_ctrl.sv
// PS/2 mouse sequencer: self-test wait, 0xF4 enable with ACK/retry, 3-byte packet decode.
// Latency: byte2 rxvalid -> fields update +1 clk -> dav rises +2 clk, high DAV_WIDTH clk.
// No backpressure on rx; commands wait in SEND while txbusy is high.
module ps2_mouse_packet_ctrl
    import mouse_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 100000,
    parameter int ACK_TIMEOUT  = 1250000,
    parameter int MAX_RETRY    = 3,
    parameter int DAV_WIDTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxdata,
    input  logic       rxvalid,
    input  logic       txbusy,
    output logic [7:0] txdata,
    output logic       txstart,
    output logic [1:0] button,
    output logic [1:0] sign,
    output logic [7:0] mousexdata,
    output logic [7:0] mouseydata,
    output logic       dav,
    output logic       ready,
    output logic       init_fail,
    output logic       pkt_err
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int DW = $clog2(DAV_WIDTH);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [DW-1:0] DAV_LOAD  = DW'(DAV_WIDTH - 1);

    logic [2:0]    state_q, state_d;
    logic [7:0]    txdata_q, txdata_d;
    logic          txstart_q, txstart_d;
    logic [RW-1:0] retry_q, retry_d;
    // Byte0 is kept in decoded form: only these fields matter after sync check.
    logic [1:0]    b0_btn_q, b0_btn_d;
    logic [1:0]    b0_sign_q, b0_sign_d;
    logic          b0_ovf_q, b0_ovf_d;
    logic [7:0]    b1_q, b1_d;
    logic [7:0]    b2_q, b2_d;
    logic          commit_q, commit_d;
    logic [1:0]    button_q, button_d;
    logic [1:0]    sign_q, sign_d;
    logic [7:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic          dav_q, dav_d;
    logic          dav_pend_q, dav_pend_d;
    logic [DW-1:0] dav_cnt_q, dav_cnt_d;
    logic          pkt_err_q, pkt_err_d;

    logic          fsm_err;
    logic          ovf_err;
    logic          byte_to;
    logic          ack_to;
    logic          timer_clr;
    logic [2:0]    nak_state;

    // The gap timer restarts on every received byte and on every state change,
    // so each wait is measured from the moment its state was entered.
    assign timer_clr = rxvalid || (state_d != state_q);

    mouse_timeout_ctr #(
        .BYTE_TIMEOUT (BYTE_TIMEOUT),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .byte_to (byte_to),
        .ack_to  (ack_to)
    );

    // A resend request or missing ACK either retries or gives up.
    assign nak_state = (retry_q < RETRY_LIM) ? ST_SEND : ST_FAIL;

    // Init/stream sequencing and packet byte capture.
    always_comb begin
        state_d   = state_q;
        txdata_d  = txdata_q;
        txstart_d = 1'b0;
        retry_d   = retry_q;
        b0_btn_d  = b0_btn_q;
        b0_sign_d = b0_sign_q;
        b0_ovf_d  = b0_ovf_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        commit_d  = 1'b0;
        fsm_err   = 1'b0;
        case (state_q)
            ST_WAIT_BAT: begin
                if (rxvalid) begin
                    if (rxdata == RSP_BAT_OK) state_d = ST_WAIT_ID;
                end else if (ack_to) begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_ID: begin
                if (rxvalid || ack_to) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!txbusy) begin
                    txdata_d  = CMD_ENABLE;
                    txstart_d = 1'b1;
                    retry_d   = retry_q + RW'(1);
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (rxvalid) begin
                    if (rxdata == RSP_ACK) begin
                        state_d = ST_PKT0;
                    end else if (rxdata == RSP_RESEND) begin
                        state_d = nak_state;
                    end
                end else if (ack_to) begin
                    state_d = nak_state;
                end
            end
            ST_PKT0: begin
                if (rxvalid) begin
                    if (rxdata[B0_SYNC]) begin
                        b0_btn_d  = {rxdata[B0_RIGHT], rxdata[B0_LEFT]};
                        b0_sign_d = {rxdata[B0_XSIGN], rxdata[B0_YSIGN]};
                        b0_ovf_d  = rxdata[B0_XOVF] | rxdata[B0_YOVF];
                        state_d   = ST_PKT1;
                    end else begin
                        fsm_err = 1'b1;
                    end
                end
            end
            ST_PKT1: begin
                if (rxvalid) begin
                    b1_d    = rxdata;
                    state_d = ST_PKT2;
                end else if (byte_to) begin
                    fsm_err = 1'b1;
                    state_d = ST_PKT0;
                end
            end
            ST_PKT2: begin
                if (rxvalid) begin
                    b2_d     = rxdata;
                    commit_d = 1'b1;
                    state_d  = ST_PKT0;
                end else if (byte_to) begin
                    fsm_err = 1'b1;
                    state_d = ST_PKT0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_WAIT_BAT;
            end
        endcase
    end

    assign ovf_err   = commit_q && b0_ovf_q;
    assign pkt_err_d = fsm_err || ovf_err;

    // Commit of a full packet to the outputs and the dav pulse shaper; a new
    // commit drops dav for one cycle so the consumer always sees a fresh edge.
    always_comb begin
        button_d   = button_q;
        sign_d     = sign_q;
        x_d        = x_q;
        y_d        = y_q;
        dav_d      = dav_q;
        dav_pend_d = 1'b0;
        dav_cnt_d  = dav_cnt_q;
        if (commit_q && !b0_ovf_q) begin
            button_d   = b0_btn_q;
            sign_d     = b0_sign_q;
            x_d        = b1_q;
            y_d        = b2_q;
            dav_d      = 1'b0;
            dav_cnt_d  = '0;
            dav_pend_d = 1'b1;
        end else if (dav_pend_q) begin
            dav_d     = 1'b1;
            dav_cnt_d = DAV_LOAD;
        end else if (dav_q) begin
            if (dav_cnt_q == '0) begin
                dav_d = 1'b0;
            end else begin
                dav_cnt_d = dav_cnt_q - DW'(1);
            end
        end
    end

    // State, packet and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_WAIT_BAT;
            txdata_q   <= 8'h00;
            txstart_q  <= 1'b0;
            retry_q    <= '0;
            b0_btn_q   <= '0;
            b0_sign_q  <= '0;
            b0_ovf_q   <= 1'b0;
            b1_q       <= '0;
            b2_q       <= '0;
            commit_q   <= 1'b0;
            button_q   <= '0;
            sign_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            dav_q      <= 1'b0;
            dav_pend_q <= 1'b0;
            dav_cnt_q  <= '0;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            txdata_q   <= txdata_d;
            txstart_q  <= txstart_d;
            retry_q    <= retry_d;
            b0_btn_q   <= b0_btn_d;
            b0_sign_q  <= b0_sign_d;
            b0_ovf_q   <= b0_ovf_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            commit_q   <= commit_d;
            button_q   <= button_d;
            sign_q     <= sign_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dav_q      <= dav_d;
            dav_pend_q <= dav_pend_d;
            dav_cnt_q  <= dav_cnt_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    assign txdata     = txdata_q;
    assign txstart    = txstart_q;
    assign button     = button_q;
    assign sign       = sign_q;
    assign mousexdata = x_q;
    assign mouseydata = y_q;
    assign dav        = dav_q;
    assign pkt_err    = pkt_err_q;
    assign ready      = is_stream(state_q);
    assign init_fail  = (state_q == ST_FAIL);

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// Directed and randomized bench for ps2_mouse_packet_ctrl with a packet-level reference model.
module tb_ps2_mouse_packet_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rxdata;
    logic       rxvalid;
    logic       txbusy;
    logic [7:0] txdata;
    logic       txstart;
    logic [1:0] button;
    logic [1:0] sign;
    logic [7:0] mousexdata;
    logic [7:0] mouseydata;
    logic       dav;
    logic       ready;
    logic       init_fail;
    logic       pkt_err;

    ps2_mouse_packet_ctrl #(
        .BYTE_TIMEOUT (50),
        .ACK_TIMEOUT  (200),
        .MAX_RETRY    (3),
        .DAV_WIDTH    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxdata     (rxdata),
        .rxvalid    (rxvalid),
        .txbusy     (txbusy),
        .txdata     (txdata),
        .txstart    (txstart),
        .button     (button),
        .sign       (sign),
        .mousexdata (mousexdata),
        .mouseydata (mouseydata),
        .dav        (dav),
        .ready      (ready),
        .init_fail  (init_fail),
        .pkt_err    (pkt_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event monitors sampled on the falling edge.
    int         tx_pulses = 0;
    logic [7:0] last_txdata = 8'h00;
    int         err_pulses = 0;
    int         dav_rises = 0;
    int         dav_run = 0;
    int         stab_viol = 0;
    logic       dav_prev = 1'b0;
    logic [19:0] dav_cap = '0;
    int         dav_runs[$];

    always @(negedge clk) begin
        if (txstart) begin
            tx_pulses   <= tx_pulses + 1;
            last_txdata <= txdata;
        end
        if (pkt_err) err_pulses <= err_pulses + 1;
        if (dav && !dav_prev) begin
            dav_rises <= dav_rises + 1;
            dav_run   <= 1;
            dav_cap   <= {button, sign, mousexdata, mouseydata};
        end else if (dav) begin
            dav_run <= dav_run + 1;
            if ({button, sign, mousexdata, mouseydata} !== dav_cap) stab_viol <= stab_viol + 1;
        end else if (dav_prev) begin
            dav_runs.push_back(dav_run);
        end
        dav_prev <= dav;
    end

    // Reference model state: the last accepted packet's fields.
    logic [1:0] exp_button;
    logic [1:0] exp_sign;
    logic [7:0] exp_x;
    logic [7:0] exp_y;
    int         exp_dav;
    int         exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxdata  = b;
        rxvalid = 1'b1;
        tick(1);
        rxvalid = 1'b0;
    endtask

    // Packet model: overflow bits drop the packet, otherwise the fields follow
    // the byte0 bit layout (left=bit0, right=bit1, X sign=bit4, Y sign=bit5).
    task automatic model_packet(input int b0, input int b1, input int b2);
        if ((b0 / 64) != 0) begin
            exp_err++;
        end else begin
            exp_button = 2'(b0 % 4);
            exp_sign   = 2'(((b0 / 16) % 2) * 2 + ((b0 / 32) % 2));
            exp_x      = 8'(b1);
            exp_y      = 8'(b2);
            exp_dav++;
        end
    endtask

    task automatic model_reset();
        exp_button = 2'b00;
        exp_sign   = 2'b00;
        exp_x      = 8'h00;
        exp_y      = 8'h00;
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_button"}, 32'(button), 32'(exp_button));
        chk({tag, "_sign"}, 32'(sign), 32'(exp_sign));
        chk({tag, "_x"}, 32'(mousexdata), 32'(exp_x));
        chk({tag, "_y"}, 32'(mouseydata), 32'(exp_y));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_txdata"}, 32'(txdata), 32'h00);
        chk({tag, "_txstart"}, 32'(txstart), 32'h0);
        chk({tag, "_button"}, 32'(button), 32'h0);
        chk({tag, "_sign"}, 32'(sign), 32'h0);
        chk({tag, "_x"}, 32'(mousexdata), 32'h0);
        chk({tag, "_y"}, 32'(mouseydata), 32'h0);
        chk({tag, "_dav"}, 32'(dav), 32'h0);
        chk({tag, "_ready"}, 32'(ready), 32'h0);
        chk({tag, "_init_fail"}, 32'(init_fail), 32'h0);
        chk({tag, "_pkt_err"}, 32'(pkt_err), 32'h0);
    endtask

    task automatic wait_txstart(input int limit, input string tag);
        int start;
        int n;
        start = tx_pulses;
        n = 0;
        while (tx_pulses == start && n < limit) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(tx_pulses - start), 32'd1);
    endtask

    task automatic do_init(input string tag);
        int base;
        base = tx_pulses;
        send_byte(8'hAA);
        send_byte(8'h00);
        wait_txstart(20, {tag, "_tx"});
        chk({tag, "_txdata"}, 32'(last_txdata), 32'hF4);
        send_byte(8'hFA);
        tick(1);
        chk({tag, "_ready"}, 32'(ready), 32'h1);
        chk({tag, "_nofail"}, 32'(init_fail), 32'h0);
        chk({tag, "_one_tx"}, 32'(tx_pulses - base), 32'd1);
    endtask

    task automatic send3_fast(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        rxvalid = 1'b1;
        rxdata = a; tick(1);
        rxdata = b; tick(1);
        rxdata = c; tick(1);
        rxvalid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_tx;
        int base_err;
        int base_dav;
        int b0, b1, b2;
        int n;

        rxdata  = 8'h00;
        rxvalid = 1'b0;
        txbusy  = 1'b0;
        reset   = 1'b1;
        exp_dav = 0;
        exp_err = 0;
        model_reset();
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(1);

        // Power-up sequence and enable handshake.
        do_init("init");

        // Reference packet with cycle-accurate dav timing.
        base_dav = dav_rises;
        send_byte(8'h19);
        send_byte(8'h05);
        send_byte(8'hFB);
        model_packet(8'h19, 8'h05, 8'hFB);
        chk("pkt1_dav_t0", 32'(dav), 32'h0);
        tick(1);
        chk("pkt1_dav_t1", 32'(dav), 32'h0);
        chk("pkt1_button", 32'(button), 32'h1);
        chk("pkt1_sign", 32'(sign), 32'h2);
        chk("pkt1_x", 32'(mousexdata), 32'h05);
        chk("pkt1_y", 32'(mouseydata), 32'hFB);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("pkt1_dav_high", 32'(dav), 32'h1);
        end
        tick(1);
        chk("pkt1_dav_end", 32'(dav), 32'h0);
        chk("pkt1_dav_rises", 32'(dav_rises - base_dav), 32'd1);
        tick(1);
        chk("pkt1_dav_run", 32'(dav_runs[$]), 32'd4);
        check_fields("pkt1_model");

        // Sync failure and overflow packet.
        base_err = err_pulses;
        base_dav = dav_rises;
        send_byte(8'h01);
        tick(2);
        chk("sync_err", 32'(err_pulses - base_err), 32'd1);
        chk("sync_ready", 32'(ready), 32'h1);
        send_byte(8'h48);
        send_byte(8'h10);
        send_byte(8'h10);
        model_packet(8'h48, 8'h10, 8'h10);
        tick(8);
        chk("ovf_err", 32'(err_pulses - base_err), 32'd2);
        chk("ovf_no_dav", 32'(dav_rises - base_dav), 32'd0);
        check_fields("ovf_hold");

        // Byte gap timeout drops the partial packet.
        base_err = err_pulses;
        base_dav = dav_rises;
        send_byte(8'h08);
        send_byte(8'h03);
        tick(60);
        chk("gap_err", 32'(err_pulses - base_err), 32'd1);
        chk("gap_no_dav", 32'(dav_rises - base_dav), 32'd0);
        send_byte(8'h0A);
        send_byte(8'h01);
        send_byte(8'h02);
        model_packet(8'h0A, 8'h01, 8'h02);
        tick(8);
        chk("gap_next_button", 32'(button), 32'h2);
        chk("gap_next_sign", 32'(sign), 32'h0);
        check_fields("gap_next");
        chk("gap_next_dav", 32'(dav_rises - base_dav), 32'd1);

        // Second commit while dav is still high.
        base_dav = dav_rises;
        send3_fast(8'h29, 8'h11, 8'h22);
        send3_fast(8'h1A, 8'h33, 8'h44);
        model_packet(8'h29, 8'h11, 8'h22);
        model_packet(8'h1A, 8'h33, 8'h44);
        tick(12);
        chk("b2b_rises", 32'(dav_rises - base_dav), 32'd2);
        chk("b2b_run_cut", 32'(dav_runs[$-1]), 32'd2);
        chk("b2b_run_full", 32'(dav_runs[$]), 32'd4);
        check_fields("b2b");

        // Randomized packets, occasional sync garbage and overflow.
        base_err = err_pulses;
        base_dav = dav_rises;
        exp_err = 0;
        exp_dav = 0;
        for (int k = 0; k < 16; k++) begin
            b0 = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) b0 = b0 % 64;
            if ((b0 / 8) % 2 == 0) begin
                send_byte(8'(b0));
                exp_err++;
                b0 = b0 + 8;
            end
            b1 = int'($urandom_range(0, 255));
            b2 = int'($urandom_range(0, 255));
            send_byte(8'(b0));
            tick(int'($urandom_range(0, 4)));
            send_byte(8'(b1));
            tick(int'($urandom_range(0, 4)));
            send_byte(8'(b2));
            model_packet(b0, b1, b2);
            tick(8);
            check_fields("rnd");
            chk("rnd_err", 32'(err_pulses - base_err), 32'(exp_err));
            chk("rnd_dav", 32'(dav_rises - base_dav), 32'(exp_dav));
        end
        chk("dav_stability", 32'(stab_viol), 32'd0);

        // Retry exhaustion, including a resend request and a busy transmitter.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_reset();
        tick(1);
        base_tx = tx_pulses;
        send_byte(8'hAA);
        send_byte(8'h00);
        wait_txstart(20, "retry_tx1");
        txbusy = 1'b1;
        send_byte(8'hFE);
        tick(10);
        chk("retry_busy_hold", 32'(tx_pulses - base_tx), 32'd1);
        txbusy = 1'b0;
        wait_txstart(5, "retry_tx2");
        wait_txstart(300, "retry_tx3");
        tick(300);
        chk("retry_total", 32'(tx_pulses - base_tx), 32'd3);
        chk("retry_fail", 32'(init_fail), 32'h1);
        chk("retry_ready", 32'(ready), 32'h0);
        send_byte(8'hFA);
        tick(250);
        chk("retry_sticky", 32'(init_fail), 32'h1);
        chk("retry_no_more_tx", 32'(tx_pulses - base_tx), 32'd3);

        // Reset mid-packet restarts in the self-test wait.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        do_init("reinit");
        send_byte(8'h09);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_mid");
        tick(1);
        reset = 1'b0;
        send_byte(8'hFA);
        tick(2);
        chk("rst_mid_bat_wait", 32'(ready), 32'h0);
        do_init("reinit2");

        // Reset during the dav window.
        send_byte(8'h0B);
        send_byte(8'h7F);
        send_byte(8'h80);
        tick(2);
        chk("rst_dav_pre", 32'(dav), 32'h1);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_dav");
        model_reset();
        tick(1);
        reset = 1'b0;
        tick(2);
        check_fields("rst_dav_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
